dbus_sram_responder: RTL and testbench

- Memory-side responder for the core's data bus: consumes dbus_req_t from the memory stage and returns dbus_resp_t.
- Models a single-port 64-bit SRAM with configurable access latency, byte-strobe writes and abort-on-drop.
- Used as the dbus target in simulation and small FPGA builds; the mirror of the core's dbus initiator.

---
 rtl/dbus_sram_responder_pkg.sv | 38 +++
 rtl/dbus_sram_responder_sram_bank_64.sv | 27 ++
 rtl/dbus_sram_responder.sv | 172 +++++++++++++++++
 tb/tb_dbus_sram_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types plus responder-local FSM state and LFSR seed.
package dbus_sram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    function automatic logic [3:0] msize_bytes(input msize_t size);
        return 4'd1 << size;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int unsigned CNT_W     = 5;

endpackage

// File: rtl/dbus_sram_responder_sram_bank_64.sv
// Single-port 64-bit word array: one-cycle read-before-write with byte enables.
module sram_bank_64 #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    strobe,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 8; i++) begin
                if (strobe[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder with fixed access latency and abort-on-drop.
// Define DBUS_RESP_RANDOM_STALL_EN to add 0..3 LFSR-driven extra wait cycles per access.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH_WORDS) * 64'd8;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_init;
    logic [63:0]      addr_q;
    msize_t           size_q;
    logic [7:0]       strobe_q;
    logic [63:0]      wdata_q;
    logic             addr_ok_q;
    logic             data_ok_q;
    logic             err_q;
    logic             zero_q;

    logic [63:0]      cur_addr;
    msize_t           cur_size;
    logic [7:0]       cur_strobe;
    logic [63:0]      cur_data;
    logic [3:0]       nbytes;
    logic             misaligned;
    logic             out_of_range;
    logic             bad;
    logic [63:0]      offset;
    logic [AW-1:0]    word_idx;
    logic             go_resp;
    logic             mem_en;
    logic [63:0]      rdata;

`ifdef DBUS_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cnt_init = CNT_W'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
    assign cnt_init = CNT_W'(LATENCY - 1);
`endif

    // In IDLE the live request is used so LATENCY==1 can respond without a latched copy.
    always_comb begin
        cur_addr   = addr_q;
        cur_size   = size_q;
        cur_strobe = strobe_q;
        cur_data   = wdata_q;
        if (state == StIdle) begin
            cur_addr   = dreq.addr;
            cur_size   = dreq.size;
            cur_strobe = dreq.strobe;
            cur_data   = dreq.data;
        end
    end

    always_comb begin
        nbytes       = msize_bytes(cur_size);
        misaligned   = |(cur_addr[3:0] & (nbytes - 4'd1));
        out_of_range = (cur_addr < BASE_ADDR) || (cur_addr >= END_ADDR);
        bad          = misaligned || out_of_range;
        offset       = cur_addr - BASE_ADDR;
        word_idx     = AW'(offset >> 3);
    end

    // The memory access happens on the edge that enters RESP, so data is ready in RESP.
    always_comb begin
        go_resp = 1'b0;
        if (reset && dreq.valid) begin
            if (state == StIdle) begin
                go_resp = (cnt_init == '0);
            end else if (state == StWait) begin
                go_resp = (cnt == CNT_W'(1));
            end
        end
        mem_en = go_resp && !bad;
    end

    sram_bank_64 #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk   (clk),
        .en    (mem_en),
        .addr  (word_idx),
        .strobe(cur_strobe),
        .wdata (cur_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            addr_q    <= '0;
            size_q    <= MSIZE1;
            strobe_q  <= '0;
            wdata_q   <= '0;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            zero_q    <= 1'b1;
`ifdef DBUS_RESP_RANDOM_STALL_EN
            lfsr      <= LFSR_SEED;
`endif
        end else begin
`ifdef DBUS_RESP_RANDOM_STALL_EN
            lfsr      <= {lfsr[14:0], lfsr_fb};
`endif
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (dreq.valid) begin
                        addr_q   <= dreq.addr;
                        size_q   <= dreq.size;
                        strobe_q <= dreq.strobe;
                        wdata_q  <= dreq.data;
                        cnt      <= cnt_init;
                        state    <= (cnt_init == '0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (!dreq.valid) begin
                        cnt   <= '0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= StResp;
                        end
                    end
                end
                StResp: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
            if (go_resp) begin
                addr_ok_q <= 1'b1;
                data_ok_q <= 1'b1;
                err_q     <= bad;
                zero_q    <= bad;
            end
        end
    end

    // zero_q only changes on a response, so data holds between accesses.
    always_comb begin
        dresp.addr_ok = addr_ok_q;
        dresp.data_ok = data_ok_q;
        dresp.data    = zero_q ? 64'd0 : rdata;
        err           = err_q;
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: model memory, latency, error and abort checks.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned LAT   = 2;
    localparam logic [63:0] BASE  = 64'h8000_0000;

`ifdef DBUS_RESP_RANDOM_STALL_EN
    localparam int LAT_MAX = LAT + 3;
    localparam int N_RAND  = 1000;
`else
    localparam int LAT_MAX = LAT;
    localparam int N_RAND  = 60;
`endif

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       err;

    exp_t        sb[$];
    logic [63:0] model [int];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] got;

    dbus_sram_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dreq (dreq),
        .dresp(dresp),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request, hold it until data_ok, then release it one cycle later.
    task automatic access(input logic [63:0] addr, input msize_t size, input logic [7:0] strobe,
                          input logic [63:0] wdata, input bit scramble, output logic [63:0] rd);
        exp_t        e;
        logic        bad;
        logic [63:0] idx;
        logic [63:0] m;
        int          k;
        int          n;
        bit          seen;
        bad = ((addr & (64'(msize_bytes(size)) - 64'd1)) != 0) || (addr < BASE) ||
              (addr >= BASE + 64'(DEPTH) * 64'd8);
        idx = ((addr - BASE) >> 3) & 64'(DEPTH - 1);
        k   = int'(idx);
        e.err = bad;
        e.chk = 1'b1;
        e.data = 64'd0;
        if (!bad) begin
            if (model.exists(k)) e.data = model[k];
            else e.chk = 1'b0;
            if (strobe != 8'h00 && (model.exists(k) || strobe == 8'hFF)) begin
                m = model.exists(k) ? model[k] : 64'd0;
                for (int i = 0; i < 8; i++) if (strobe[i]) m[8*i +: 8] = wdata[8*i +: 8];
                model[k] = m;
            end
        end
        sb.push_back(e);
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = size;
        dreq.strobe = strobe;
        dreq.data   = wdata;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (dresp.data_ok) seen = 1'b1;
            else if (scramble && n == 1) begin
                dreq.addr   = addr ^ 64'h8;
                dreq.strobe = ~strobe;
                dreq.data   = ~wdata;
            end
        end
        e = sb.pop_front();
        rd = 64'd0;
        check_eq("resp_seen", 64'(seen), 64'd1);
        if (seen) begin
            check_eq("latency_ok", 64'(n >= LAT && n <= LAT_MAX), 64'd1);
            check_eq("addr_ok", 64'(dresp.addr_ok), 64'd1);
            check_eq("err", 64'(err), 64'(e.err));
            if (e.chk) check_eq("rdata", dresp.data, e.data);
            rd = dresp.data;
        end
        @(posedge clk);
        #1;
        dreq.valid = 1'b0;
        check_eq("data_ok_clears", 64'(dresp.data_ok), 64'd0);
        check_eq("err_clears", 64'(err), 64'd0);
        if (seen) check_eq("data_holds", dresp.data, rd);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (dresp.data_ok) hits++;
        end
        check_eq(tag, 64'(hits), 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        dreq  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_addr_ok", 64'(dresp.addr_ok), 64'd0);
        check_eq("rst_data_ok", 64'(dresp.data_ok), 64'd0);
        check_eq("rst_data", dresp.data, 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        reset = 1'b1;

        for (int w = 0; w < 16; w++) begin
            access(BASE + 64'(w) * 64'd8, MSIZE8, 8'hFF, {$urandom, $urandom}, 1'b0, got);
        end
        access(BASE + 64'h7FF8, MSIZE8, 8'hFF, 64'h0BAD_F00D_CAFE_0001, 1'b0, got);

        access(BASE + 64'h10, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, got);
        access(BASE + 64'h10, MSIZE8, 8'h00, 64'd0, 1'b0, got);
        check_eq("t1_read", got, 64'h1122_3344_5566_7788);

        access(BASE + 64'h10, MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, got);
        access(BASE + 64'h13, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000, 1'b0, got);
        access(BASE + 64'h10, MSIZE8, 8'h00, 64'd0, 1'b0, got);
        check_eq("t2_byte_merge", got, 64'hFFFF_FFFF_ABFF_FFFF);

        access(BASE + 64'h2, MSIZE4, 8'h3C, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, got);
        check_eq("t3_misaligned_data", got, 64'd0);
        access(BASE, MSIZE8, 8'h00, 64'd0, 1'b0, got);
        access(BASE + 64'h6, MSIZE2, 8'h00, 64'd0, 1'b0, got);

        access(64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 1'b0, got);
        check_eq("t4_below_base", got, 64'd0);
        access(BASE + 64'h8000, MSIZE8, 8'hFF, 64'h5555_5555_5555_5555, 1'b0, got);
        access(BASE, MSIZE8, 8'h00, 64'd0, 1'b0, got);
        access(BASE + 64'h7FF8, MSIZE8, 8'h00, 64'd0, 1'b0, got);

        // Abort: valid drops one cycle after acceptance.
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h20;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hA5A5_A5A5_A5A5_A5A5;
        @(posedge clk);
        #1;
        dreq.valid = 1'b0;
        expect_quiet("abort_no_resp", 8);
        access(BASE + 64'h20, MSIZE8, 8'h00, 64'd0, 1'b0, got);

        access(BASE + 64'h10, MSIZE8, 8'h00, 64'd0, 1'b1, got);
        access(BASE + 64'h30, MSIZE8, 8'h0F, 64'h0123_4567_89AB_CDEF, 1'b1, got);
        access(BASE + 64'h30, MSIZE8, 8'h00, 64'd0, 1'b0, got);

        // Reset asserted in WAIT, on the edge that would complete the write.
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h28;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h7777_7777_7777_7777;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dreq.valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_data_ok", 64'(dresp.data_ok), 64'd0);
        check_eq("midrst_data", dresp.data, 64'd0);
        check_eq("midrst_err", 64'(err), 64'd0);
        reset = 1'b1;
        expect_quiet("midrst_no_resp", 4);
        access(BASE + 64'h28, MSIZE8, 8'h00, 64'd0, 1'b0, got);

        for (int i = 0; i < N_RAND; i++) begin
            msize_t      sz;
            logic [63:0] a;
            logic [7:0]  st;
            sz = msize_t'($urandom_range(3, 0));
            a  = BASE + 64'($urandom_range(15, 0)) * 64'd8 +
                 (64'($urandom_range(7, 0)) & ~(64'(msize_bytes(sz)) - 64'd1));
            st = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
            access(a, sz, st, {$urandom, $urandom}, 1'($urandom), got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
